// File: rtl/imem_dp_loadable.sv
// ============================================================================
// imem_dp_loadable
//   Dual-read-port instruction memory with 1-cycle synchronous reads and a
//   run-time sequential program loader.  Port 0 feeds the fetch stage, port 1
//   serves prefetch/debug reads.  While the loader is busy (LOAD) or just
//   finishing (DONE), fetch requests are dropped rather than queued.
//
//   Optional feature macro: IMEM_PARITY_EN
//     defined   : each word carries an even-parity bit written with it; every
//                 accepted in-range read is checked and par_err pulses with the
//                 matching fN_valid (OR of both ports).
//     undefined : no parity storage, par_err is constant 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   f_ready             fetch requests accepted (loader idle)
//   f0_req/f0_addr      port 0 read request / word address
//   f0_rdata/f0_valid   port 0 read data / 1-cycle valid per accepted request
//   f1_*                same as port 0, for port 1
//   ld_start            pulse: begin a program load at word 0
//   ld_valid/ld_data    program word to write this cycle
//   ld_last             final word of the program (qualified by ld_valid)
//   ld_busy             loader in LOAD
//   ld_done             1-cycle pulse when a load completes
//   par_err             parity error on a valid read
// ============================================================================
module imem_dp_loadable #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] OOR_WORD   = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  f_ready,
    input  logic                  f0_req,
    input  logic [ADDR_WIDTH-1:0] f0_addr,
    output logic [DATA_WIDTH-1:0] f0_rdata,
    output logic                  f0_valid,
    input  logic                  f1_req,
    input  logic [ADDR_WIDTH-1:0] f1_addr,
    output logic [DATA_WIDTH-1:0] f1_rdata,
    output logic                  f1_valid,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_busy,
    output logic                  ld_done,
    output logic                  par_err
);

    // Index width covers DEPTH entries; addresses are range-checked against
    // DEPTH one bit wider than the port so the compare never degenerates when
    // DEPTH == 2**ADDR_WIDTH.
    localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]      PTR_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      PTR_ONE   = IDX_W'(1);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;

    // Even parity: the stored bit makes the XOR over the whole entry zero.
    function automatic logic even_par(input logic [DATA_WIDTH-1:0] w);
        return ^w;
    endfunction

    function automatic logic [MEM_W-1:0] encode(input logic [DATA_WIDTH-1:0] w);
        return {even_par(w), w};
    endfunction

    function automatic logic par_bad(input logic [MEM_W-1:0] e);
        return ^e;
    endfunction
`else
    localparam int MEM_W = DATA_WIDTH;

    function automatic logic [MEM_W-1:0] encode(input logic [DATA_WIDTH-1:0] w);
        return w;
    endfunction
`endif

    localparam logic [MEM_W-1:0] INIT_ENTRY = encode(OOR_WORD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Power-up contents are the NOP word; reset deliberately leaves them alone.
    logic [MEM_W-1:0] mem_r [DEPTH] = '{default: INIT_ENTRY};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_nxt_s;
    logic             wr_en_s;
    logic             wr_last_s;

    logic             acc0_s;
    logic             acc1_s;
    logic             in0_s;
    logic             in1_s;
    logic [MEM_W-1:0] ent0_s;
    logic [MEM_W-1:0] ent1_s;
    logic             perr_s;

    assign f_ready = (state_r == ST_IDLE);
    assign ld_busy = (state_r == ST_LOAD);
    assign ld_done = (state_r == ST_DONE);

    assign acc0_s  = f0_req && (state_r == ST_IDLE);
    assign acc1_s  = f1_req && (state_r == ST_IDLE);
    assign in0_s   = ({1'b0, f0_addr} < DEPTH_EXT);
    assign in1_s   = ({1'b0, f1_addr} < DEPTH_EXT);
    assign ent0_s  = mem_r[f0_addr[IDX_W-1:0]];
    assign ent1_s  = mem_r[f1_addr[IDX_W-1:0]];

`ifdef IMEM_PARITY_EN
    assign perr_s  = (acc0_s && in0_s && par_bad(ent0_s)) ||
                     (acc1_s && in1_s && par_bad(ent1_s));
`else
    assign perr_s  = 1'b0;
`endif

    // Loader next-state, write enable and write-pointer update.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        wr_en_s     = 1'b0;
        wr_last_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ld_start) begin
                    state_nxt_s = ST_LOAD;
                    ptr_nxt_s   = PTR_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    wr_en_s   = 1'b1;
                    // Filling the final slot ends the load even without ld_last.
                    wr_last_s = ld_last || (ptr_r == LAST_IDX);
                    if (ptr_r == LAST_IDX) begin
                        ptr_nxt_s = PTR_ZERO;
                    end else begin
                        ptr_nxt_s = ptr_r + PTR_ONE;
                    end
                    if (wr_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = PTR_ZERO;
            end
        endcase
    end

    // Loader state and write-pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= PTR_ZERO;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Memory write port; a write coinciding with reset is suppressed.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_r[ptr_r] <= encode(ld_data);
        end
    end

    // Registered read ports: valid pulses per accepted request, data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            f0_valid <= 1'b0;
            f1_valid <= 1'b0;
            f0_rdata <= {DATA_WIDTH{1'b0}};
            f1_rdata <= {DATA_WIDTH{1'b0}};
            par_err  <= 1'b0;
        end else begin
            f0_valid <= acc0_s;
            f1_valid <= acc1_s;
            if (acc0_s) begin
                f0_rdata <= in0_s ? ent0_s[DATA_WIDTH-1:0] : OOR_WORD;
            end
            if (acc1_s) begin
                f1_rdata <= in1_s ? ent1_s[DATA_WIDTH-1:0] : OOR_WORD;
            end
            par_err  <= perr_s;
        end
    end

endmodule

// File: tb/tb_imem_dp_loadable.sv
module tb_imem_dp_loadable;

    localparam int          DW    = 32;
    localparam int          AW    = 7;
    localparam int          DEPTH = 64;
    localparam logic [31:0] OOR   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_ready;
    logic          f0_req;
    logic [AW-1:0] f0_addr;
    logic [DW-1:0] f0_rdata;
    logic          f0_valid;
    logic          f1_req;
    logic [AW-1:0] f1_addr;
    logic [DW-1:0] f1_rdata;
    logic          f1_valid;
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_busy;
    logic          ld_done;
    logic          par_err;

    int errors = 0;
    int checks = 0;

    // Reference model: plain array of program words plus last-returned data.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;

    imem_dp_loadable #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .OOR_WORD  (OOR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .f_ready (f_ready),
        .f0_req  (f0_req),
        .f0_addr (f0_addr),
        .f0_rdata(f0_rdata),
        .f0_valid(f0_valid),
        .f1_req  (f1_req),
        .f1_addr (f1_addr),
        .f1_rdata(f1_rdata),
        .f1_valid(f1_valid),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_data (ld_data),
        .ld_last (ld_last),
        .ld_busy (ld_busy),
        .ld_done (ld_done),
        .par_err (par_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [AW-1:0] a);
        if (int'(a) < DEPTH) return model_mem[int'(a)];
        return OOR;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read cycle in IDLE; updates the expected held data.
    task automatic drive_read(input logic r0, input logic [AW-1:0] a0,
                              input logic r1, input logic [AW-1:0] a1);
        f0_req = r0; f0_addr = a0; f1_req = r1; f1_addr = a1;
        tick();
        f0_req = 1'b0; f1_req = 1'b0;
        if (r0) exp_d0 = model_word(a0);
        if (r1) exp_d1 = model_word(a1);
    endtask

    // Load a program; fetches are thrown at the memory throughout.
    task automatic load_words(input logic [31:0] words [$], input bit use_last,
                              input int gap_pct, output int busy_cycles, output int done_pulses);
        int  n;
        int  i;
        int  guard;
        bit  gap;
        bit  fin;
        logic r0;
        logic r1;
        n = words.size();
        busy_cycles = 0;
        done_pulses = 0;
        r0 = 1'($urandom_range(0, 1));
        r1 = 1'($urandom_range(0, 1));
        ld_start = 1'b1;
        drive_read(r0, AW'($urandom_range(0, 127)), r1, AW'($urandom_range(0, 127)));
        ld_start = 1'b0;
        checks++;
        if (f0_valid !== r0 || f1_valid !== r1)
            begin errors++; $display("FAIL start_fetch_valid: got %b%b want %b%b", f0_valid, f1_valid, r0, r1); end
        checks++;
        if (f0_rdata !== exp_d0 || f1_rdata !== exp_d1)
            begin errors++; $display("FAIL start_fetch_data: got %h/%h want %h/%h", f0_rdata, f1_rdata, exp_d0, exp_d1); end
        if (ld_busy === 1'b1) busy_cycles++;
        i = 0;
        guard = 0;
        while (i < n && guard < 2000) begin
            guard++;
            gap      = ($urandom_range(0, 99) < gap_pct);
            ld_valid = !gap;
            ld_data  = words[i];
            ld_last  = gap ? 1'($urandom_range(0, 1)) : (use_last && (i == n - 1));
            ld_start = ($urandom_range(0, 3) == 0);
            f0_req   = 1'($urandom_range(0, 1));
            f1_req   = 1'($urandom_range(0, 1));
            f0_addr  = AW'($urandom_range(0, 127));
            f1_addr  = AW'($urandom_range(0, 127));
            tick();
            if (!gap) begin
                model_mem[i] = words[i];
                i++;
            end
            fin = (i == n);
            checks++;
            if (ld_busy !== !fin || ld_done !== fin || f_ready !== 1'b0)
                begin errors++; $display("FAIL load_state: busy/done/ready got %b%b%b want %b%b0", ld_busy, ld_done, f_ready, !fin, fin); end
            checks++;
            if (f0_valid !== 1'b0 || f1_valid !== 1'b0 || f0_rdata !== exp_d0 || f1_rdata !== exp_d1)
                begin errors++; $display("FAIL load_gating: valid %b%b data %h/%h want 00 %h/%h", f0_valid, f1_valid, f0_rdata, f1_rdata, exp_d0, exp_d1); end
            if (ld_busy === 1'b1) busy_cycles++;
            if (ld_done === 1'b1) done_pulses++;
        end
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
        // DONE cycle: fetches still dropped, then back to IDLE.
        f0_req = 1'b1; f1_req = 1'b1;
        tick();
        f0_req = 1'b0; f1_req = 1'b0;
        checks++;
        if (ld_done !== 1'b0 || ld_busy !== 1'b0 || f_ready !== 1'b1 || f0_valid !== 1'b0 || f1_valid !== 1'b0)
            begin errors++; $display("FAIL done_exit: done/busy/ready/v0/v1 got %b%b%b%b%b want 00100", ld_done, ld_busy, f_ready, f0_valid, f1_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_d0 = 32'h0; exp_d1 = 32'h0;
        checks++;
        if ({f0_valid, f1_valid, ld_busy, ld_done, par_err, f_ready} !== 6'b000001)
            begin errors++; $display("FAIL reset_ctrl: got %b want 000001", {f0_valid, f1_valid, ld_busy, ld_done, par_err, f_ready}); end
        checks++;
        if (f0_rdata !== 32'h0 || f1_rdata !== 32'h0)
            begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", f0_rdata, f1_rdata); end
    endtask

    task automatic test_program();
        logic [31:0] prog [$];
        int busy;
        int done;
        prog = '{32'h3408_0005, 32'h3409_000A, 32'h0109_5021, 32'h0128_5823};
        load_words(prog, 1'b1, 0, busy, done);
        checks++;
        if (busy != 4) begin errors++; $display("FAIL prog_busy_cycles: got %0d want 4", busy); end
        checks++;
        if (done != 1) begin errors++; $display("FAIL prog_done_pulses: got %0d want 1", done); end
        drive_read(1'b1, 7'd2, 1'b1, 7'd10);
        checks++;
        if (f0_valid !== 1'b1 || f0_rdata !== 32'h0109_5021)
            begin errors++; $display("FAIL prog_read2: got v=%b %h want v=1 01095021", f0_valid, f0_rdata); end
        checks++;
        if (f1_valid !== 1'b1 || f1_rdata !== OOR)
            begin errors++; $display("FAIL unwritten_word: got v=%b %h want v=1 %h", f1_valid, f1_rdata, OOR); end
    endtask

    task automatic test_dual_port();
        drive_read(1'b1, 7'd0, 1'b1, 7'd3);
        checks++;
        if (f0_valid !== 1'b1 || f1_valid !== 1'b1 || f0_rdata !== 32'h3408_0005 || f1_rdata !== 32'h0128_5823)
            begin errors++; $display("FAIL dual_read: got %b%b %h/%h want 11 34080005/01285823", f0_valid, f1_valid, f0_rdata, f1_rdata); end
        drive_read(1'b1, 7'd1, 1'b1, 7'd1);
        checks++;
        if (f0_rdata !== 32'h3409_000A || f1_rdata !== 32'h3409_000A || f0_valid !== 1'b1 || f1_valid !== 1'b1)
            begin errors++; $display("FAIL same_addr: got %b%b %h/%h want 11 3409000a/3409000a", f0_valid, f1_valid, f0_rdata, f1_rdata); end
        // No request: valid drops, data holds.
        drive_read(1'b0, 7'd2, 1'b0, 7'd2);
        checks++;
        if (f0_valid !== 1'b0 || f1_valid !== 1'b0 || f0_rdata !== 32'h3409_000A || f1_rdata !== 32'h3409_000A)
            begin errors++; $display("FAIL hold_data: got %b%b %h/%h want 00 3409000a/3409000a", f0_valid, f1_valid, f0_rdata, f1_rdata); end
    endtask

    task automatic test_random_reads(input int n);
        for (int k = 0; k < n; k++) begin
            logic r0;
            logic r1;
            logic [AW-1:0] a0;
            logic [AW-1:0] a1;
            r0 = 1'($urandom_range(0, 3) != 0);
            r1 = 1'($urandom_range(0, 3) != 0);
            a0 = AW'($urandom_range(0, 127));
            a1 = (k % 5 == 0) ? a0 : AW'($urandom_range(0, 127));
            drive_read(r0, a0, r1, a1);
            checks++;
            if (f0_valid !== r0 || f0_rdata !== exp_d0)
                begin errors++; $display("FAIL rand_p0 addr %0d: got v=%b %h want v=%b %h", a0, f0_valid, f0_rdata, r0, exp_d0); end
            checks++;
            if (f1_valid !== r1 || f1_rdata !== exp_d1)
                begin errors++; $display("FAIL rand_p1 addr %0d: got v=%b %h want v=%b %h", a1, f1_valid, f1_rdata, r1, exp_d1); end
            checks++;
            if (par_err !== 1'b0)
                begin errors++; $display("FAIL rand_par_err: got %b want 0", par_err); end
        end
    endtask

    task automatic test_idle_ld_ignored();
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ld_last  = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (ld_busy !== 1'b0 || ld_done !== 1'b0 || f_ready !== 1'b1)
                begin errors++; $display("FAIL idle_ld_state: busy/done/ready got %b%b%b want 001", ld_busy, ld_done, f_ready); end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_read(1'b1, AW'(k), 1'b0, 7'd0);
            checks++;
            if (f0_rdata !== exp_d0)
                begin errors++; $display("FAIL idle_ld_word%0d: got %h want %h", k, f0_rdata, exp_d0); end
        end
    endtask

    task automatic test_full_load();
        logic [31:0] prog [$];
        int busy;
        int done;
        for (int k = 0; k < DEPTH; k++) prog.push_back($urandom);
        load_words(prog, 1'b0, 25, busy, done);
        checks++;
        if (done != 1) begin errors++; $display("FAIL full_done_pulses: got %0d want 1", done); end
        drive_read(1'b1, 7'd63, 1'b1, 7'd100);
        checks++;
        if (f0_valid !== 1'b1 || f0_rdata !== prog[63])
            begin errors++; $display("FAIL full_read63: got v=%b %h want v=1 %h", f0_valid, f0_rdata, prog[63]); end
        checks++;
        if (f1_valid !== 1'b1 || f1_rdata !== OOR || par_err !== 1'b0)
            begin errors++; $display("FAIL oor_read100: got v=%b %h pe=%b want v=1 %h pe=0", f1_valid, f1_rdata, par_err, OOR); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] w [4];
        logic [31:0] old2;
        for (int k = 0; k < 4; k++) w[k] = $urandom ^ model_mem[k];
        old2 = model_mem[2];
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1; ld_data = w[k]; ld_last = 1'b0;
            tick();
            model_mem[k] = w[k];
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_d0 = 32'h0; exp_d1 = 32'h0;
        checks++;
        if ({ld_busy, ld_done, f_ready, f0_valid, f1_valid} !== 5'b00100)
            begin errors++; $display("FAIL abort_state: got %b want 00100", {ld_busy, ld_done, f_ready, f0_valid, f1_valid}); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ld_done !== 1'b0 || ld_busy !== 1'b0)
                begin errors++; $display("FAIL abort_no_done: done/busy got %b%b want 00", ld_done, ld_busy); end
        end
        drive_read(1'b1, 7'd1, 1'b1, 7'd2);
        checks++;
        if (f0_rdata !== w[1])
            begin errors++; $display("FAIL abort_new_word1: got %h want %h", f0_rdata, w[1]); end
        checks++;
        if (f1_rdata !== old2)
            begin errors++; $display("FAIL abort_old_word2: got %h want %h", f1_rdata, old2); end
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        dut.mem_r[5][3] = ~dut.mem_r[5][3];
        drive_read(1'b1, 7'd5, 1'b1, 7'd6);
        checks++;
        if (f0_valid !== 1'b1 || par_err !== 1'b1)
            begin errors++; $display("FAIL par_flag: got v=%b pe=%b want v=1 pe=1", f0_valid, par_err); end
        drive_read(1'b1, 7'd6, 1'b1, 7'd100);
        checks++;
        if (par_err !== 1'b0)
            begin errors++; $display("FAIL par_clean: got pe=%b want 0", par_err); end
        dut.mem_r[5][3] = ~dut.mem_r[5][3];
        drive_read(1'b1, 7'd5, 1'b0, 7'd0);
        checks++;
        if (par_err !== 1'b0 || f0_rdata !== exp_d0)
            begin errors++; $display("FAIL par_restored: got pe=%b %h want pe=0 %h", par_err, f0_rdata, exp_d0); end
    endtask
`endif

    initial begin
        for (int k = 0; k < DEPTH; k++) model_mem[k] = OOR;
        rst = 1'b1;
        f0_req = 1'b0; f0_addr = 7'd0; f1_req = 1'b0; f1_addr = 7'd0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
        exp_d0 = 32'h0; exp_d1 = 32'h0;
        test_reset();
        test_program();
        test_dual_port();
        test_random_reads(40);
        test_idle_ld_ignored();
        test_full_load();
        test_random_reads(60);
        test_reset_abort();
        test_random_reads(20);
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
